// File: rtl/mips_multi_ctrl_ws_pkg.sv
// rtl/mips_multi_ctrl_ws_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_multi_ctrl_ws_pkg;

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_RTYPEEX = 5'd6,
        S_RTYPEWB = 5'd7,
        S_BEQEX   = 5'd8,
        S_BNEEX   = 5'd9,
        S_IMMEX   = 5'd10,
        S_IMMWB   = 5'd11,
        S_JEX     = 5'd12,
        S_TRAP    = 5'd13
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_XOR   = 3'd5,
        ALUOP_SLT   = 3'd6
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRLV  = 6'b000110;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;

    localparam logic [2:0] SRCB_REG     = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_SIGNIMM = 3'd2;
    localparam logic [2:0] SRCB_BRANCH  = 3'd3;
    localparam logic [2:0] SRCB_ZEROIMM = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multi_aludec.sv
// rtl/mips_multi_aludec.sv - ALU decoder: aluop + funct to alucontrol, flags unknown R-type funct
module mips_multi_aludec
    import mips_multi_ctrl_ws_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol,
    output logic       funct_illegal
);

    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_XOR: alucontrol = ALU_XOR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_XOR:  alucontrol = ALU_XOR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_SRLV: alucontrol = ALU_SRLV;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl_ws.sv
// rtl/mips_multi_ctrl_ws.sv - multicycle MIPS main FSM with memory wait states, bus timeout and trap
module mips_multi_ctrl_ws
    import mips_multi_ctrl_ws_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int BYTE_LD_EN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       lbu,
    output logic       lbsign,
    output logic       illegal,
    output logic       buserr
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_CNT = CW'(MEM_TIMEOUT);

    state_t        state, state_next;
    logic [CW-1:0] wcnt;
    logic [2:0]    aluop;
    logic [3:0]    dec_alucontrol;
    logic          funct_illegal;
    logic          pcwrite, branch, bne_br;
    logic          mem_state, tmo;
    logic          is_lb, is_lbu;

    mips_multi_aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (dec_alucontrol),
        .funct_illegal (funct_illegal)
    );

    assign is_lb     = (BYTE_LD_EN != 0) && (op == OP_LB);
    assign is_lbu    = (BYTE_LD_EN != 0) && (op == OP_LBU);
    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign tmo       = (MEM_TIMEOUT != 0) && mem_state && (wcnt == TMO_CNT) && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            // Counter restarts on every entry to a memory state, including FETCH after a timeout.
            if (state_next != state || mem_ready || tmo || !mem_state || MEM_TIMEOUT == 0)
                wcnt <= '0;
            else
                wcnt <= wcnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne_br     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        lbu        = 1'b0;
        lbsign     = 1'b0;
        illegal    = 1'b0;
        buserr     = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    alusrcb = SRCB_FOUR;
                    if (tmo) begin
                        buserr = 1'b1;
                    end else begin
                        memread = 1'b1;
                        if (mem_ready) begin
                            irwrite    = 1'b1;
                            pcwrite    = 1'b1;
                            state_next = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    alusrcb = SRCB_BRANCH;
                    if (op == OP_LW || op == OP_SW || is_lb || is_lbu)
                        state_next = S_MEMADR;
                    else if (op == OP_RTYPE)
                        state_next = S_RTYPEEX;
                    else if (op == OP_BEQ)
                        state_next = S_BEQEX;
                    else if (op == OP_BNE)
                        state_next = S_BNEEX;
                    else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI ||
                             op == OP_XORI || op == OP_SLTI)
                        state_next = S_IMMEX;
                    else if (op == OP_J)
                        state_next = S_JEX;
                    else
                        state_next = S_TRAP;
                end
                S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_SIGNIMM;
                    state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord   = 1'b1;
                    lbu    = is_lb || is_lbu;
                    lbsign = is_lb;
                    if (tmo) begin
                        buserr     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        memread = 1'b1;
                        if (mem_ready)
                            state_next = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    iord = 1'b1;
                    if (tmo) begin
                        buserr     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        memwrite = 1'b1;
                        if (mem_ready)
                            state_next = S_FETCH;
                    end
                end
                S_RTYPEEX: begin
                    alusrca    = 1'b1;
                    aluop      = ALUOP_FUNCT;
                    state_next = funct_illegal ? S_TRAP : S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    state_next = S_FETCH;
                end
                S_IMMEX: begin
                    alusrca = 1'b1;
                    alusrcb = (op == OP_ADDI || op == OP_SLTI) ? SRCB_SIGNIMM : SRCB_ZEROIMM;
                    case (op)
                        OP_ANDI: aluop = ALUOP_AND;
                        OP_ORI:  aluop = ALUOP_OR;
                        OP_XORI: aluop = ALUOP_XOR;
                        OP_SLTI: aluop = ALUOP_SLT;
                        default: aluop = ALUOP_ADD;
                    endcase
                    state_next = S_IMMWB;
                end
                S_IMMWB: begin
                    regwrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BEQEX, S_BNEEX: begin
                    alusrca    = 1'b1;
                    aluop      = ALUOP_SUB;
                    pcsrc      = PCSRC_ALUOUT;
                    branch     = (state == S_BEQEX);
                    bne_br     = (state == S_BNEEX);
                    state_next = S_FETCH;
                end
                S_JEX: begin
                    pcwrite    = 1'b1;
                    pcsrc      = PCSRC_JUMP;
                    state_next = S_FETCH;
                end
                S_TRAP: begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    assign alucontrol = reset ? dec_alucontrol : 4'b0000;
    assign pcen       = pcwrite | (branch & zero) | (bne_br & ~zero);

endmodule

// File: tb/tb_mips_multi_ctrl_ws.sv
// tb/tb_mips_multi_ctrl_ws.sv - directed self-checking bench for mips_multi_ctrl_ws
module tb_mips_multi_ctrl_ws;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       lbu, lbsign, illegal, buserr;

    logic       pcen_nb, memread_nb, memwrite_nb, irwrite_nb, regwrite_nb, alusrca_nb, iord_nb;
    logic       memtoreg_nb, regdst_nb;
    logic [2:0] alusrcb_nb;
    logic [1:0] pcsrc_nb;
    logic [3:0] alucontrol_nb;
    logic       lbu_nb, lbsign_nb, illegal_nb, buserr_nb;

    logic [21:0] ctl, ctl_nb;
    assign ctl = {pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol, lbu, lbsign, illegal, buserr};
    assign ctl_nb = {pcen_nb, memread_nb, memwrite_nb, irwrite_nb, regwrite_nb, alusrca_nb, iord_nb,
                     memtoreg_nb, regdst_nb, alusrcb_nb, pcsrc_nb, alucontrol_nb, lbu_nb, lbsign_nb,
                     illegal_nb, buserr_nb};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_multi_ctrl_ws #(.MEM_TIMEOUT(4), .BYTE_LD_EN(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .lbu(lbu), .lbsign(lbsign), .illegal(illegal), .buserr(buserr)
    );

    mips_multi_ctrl_ws #(.MEM_TIMEOUT(4), .BYTE_LD_EN(0)) dut_nb (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen_nb), .memread(memread_nb), .memwrite(memwrite_nb), .irwrite(irwrite_nb),
        .regwrite(regwrite_nb), .alusrca(alusrca_nb), .iord(iord_nb), .memtoreg(memtoreg_nb),
        .regdst(regdst_nb), .alusrcb(alusrcb_nb), .pcsrc(pcsrc_nb), .alucontrol(alucontrol_nb),
        .lbu(lbu_nb), .lbsign(lbsign_nb), .illegal(illegal_nb), .buserr(buserr_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [5:0] o, input logic [5:0] f, input logic z);
        reset = 1'b0; mem_ready = 1'b0; op = o; funct = f; zero = z;
        @(negedge clk); @(negedge clk); #1;
        check("rst_outs", {10'd0, ctl}, 32'd0);
    endtask

    task automatic cyc(input logic mr);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = mr;
        #1;
    endtask

    logic [5:0] br_op [4] = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
    logic       br_z  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       br_pc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        // zero-wait add
        do_reset(6'b000000, 6'b100000, 1'b0);
        cyc(1'b1);
        check("add_f_memread", memread, 1); check("add_f_irwrite", irwrite, 1);
        check("add_f_pcen", pcen, 1); check("add_f_srcb", alusrcb, 1);
        check("add_f_aluc", alucontrol, 4'b0010); check("add_f_iord", iord, 0);
        cyc(1'b1);
        check("add_d_srcb", alusrcb, 3); check("add_d_memread", memread, 0);
        cyc(1'b1);
        check("add_ex_srca", alusrca, 1); check("add_ex_srcb", alusrcb, 0);
        check("add_ex_aluc", alucontrol, 4'b0010);
        cyc(1'b1);
        check("add_wb_regwrite", regwrite, 1); check("add_wb_regdst", regdst, 1);
        cyc(1'b1);
        check("add_next_fetch", memread, 1);

        // fetch with 3 wait cycles
        do_reset(6'b000000, 6'b100010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            check("fw_memread", memread, 1); check("fw_irwrite", irwrite, 0); check("fw_pcen", pcen, 0);
        end
        cyc(1'b1);
        check("fw_memread4", memread, 1); check("fw_irwrite4", irwrite, 1); check("fw_pcen4", pcen, 1);
        cyc(1'b0);
        check("fw_decode", alusrcb, 3); check("fw_decode_rd", memread, 0);

        // lb / lbu with 2 waits; second instance has byte loads disabled
        for (int k = 0; k < 2; k++) begin
            do_reset((k == 0) ? 6'b100000 : 6'b100100, 6'b000000, 1'b0);
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
            check("lb_adr_srca", alusrca, 1); check("lb_adr_srcb", alusrcb, 2);
            check("nb_trap_illegal", illegal_nb, 1);
            for (int i = 0; i < 2; i++) begin
                cyc(1'b0);
                check("lb_rd_memread", memread, 1); check("lb_rd_iord", iord, 1);
                check("lb_lbu", lbu, 1); check("lb_lbsign", lbsign, (k == 0) ? 1 : 0);
                if (i == 0) check("nb_after_trap", illegal_nb, 0);
            end
            cyc(1'b1);
            check("lb_rd_ready", memread, 1);
            cyc(1'b0);
            check("lb_wb_regwrite", regwrite, 1); check("lb_wb_memtoreg", memtoreg, 1);
            check("lb_wb_regdst", regdst, 0); check("lb_wb_memread", memread, 0);
        end

        // branches
        for (int k = 0; k < 4; k++) begin
            do_reset(br_op[k], 6'b000000, br_z[k]);
            cyc(1'b1); cyc(1'b0); cyc(1'b0);
            check("br_pcen", pcen, br_pc[k]); check("br_pcsrc", pcsrc, 1);
            check("br_aluc", alucontrol, 4'b1010); check("br_srca", alusrca, 1);
        end

        // andi / slti / j
        do_reset(6'b001100, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("andi_srcb", alusrcb, 4); check("andi_aluc", alucontrol, 4'b0000);
        cyc(1'b0);
        check("andi_wb", regwrite, 1); check("andi_regdst", regdst, 0);
        do_reset(6'b001010, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("slti_srcb", alusrcb, 2); check("slti_aluc", alucontrol, 4'b1011);
        do_reset(6'b000010, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("j_pcen", pcen, 1); check("j_pcsrc", pcsrc, 2);

        // sw timeout with MEM_TIMEOUT=4
        do_reset(6'b101011, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            check("sw_memwrite", memwrite, 1); check("sw_nobuserr", buserr, 0); check("sw_memread", memread, 0);
        end
        cyc(1'b0);
        check("sw_buserr", buserr, 1); check("sw_drop", memwrite, 0);
        check("sw_tmo_pcen", pcen, 0); check("sw_tmo_regwrite", regwrite, 0);
        cyc(1'b0);
        check("sw_fetch", memread, 1); check("sw_buserr_off", buserr, 0); check("sw_fetch_iord", iord, 0);

        // illegal opcode and illegal funct
        do_reset(6'b111111, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("ill_op", illegal, 1); check("ill_op_rw", regwrite, 0); check("ill_op_mw", memwrite, 0);
        cyc(1'b0);
        check("ill_op_pulse", illegal, 0); check("ill_op_fetch", memread, 1);
        do_reset(6'b000000, 6'b111111, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("ill_fn_ex", illegal, 0);
        cyc(1'b0);
        check("ill_fn", illegal, 1); check("ill_fn_rw", regwrite, 0);

        // asynchronous reset during MEMRD
        do_reset(6'b100011, 6'b000000, 1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
        check("rmid_memread", memread, 1); check("rmid_iord", iord, 1);
        #1 reset = 1'b0;
        #1 check("rmid_outs", {10'd0, ctl}, 32'd0);
        cyc(1'b0);
        check("rmid_fetch", memread, 1); check("rmid_fetch_iord", iord, 0); check("rmid_srcb", alusrcb, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
